pipelined_data_memory: RTL and testbench

Parametrised, byte-addressable data memory for the MEM stage, successor to the single-cycle word memory.
- Byte-lane writes placed at the address offset; offset-aware loads with sign/zero extension.
- Misalignment and illegal-func3 fault reporting.
- Valid/ready request handshake with a fixed, configurable response latency.
- Hardware clear-on-reset sequencer, since an asynchronous reset cannot clear the array.

---
 rtl/pipelined_data_memory.sv | 256 +++++++++++++++++++++++++
 tb/tb_pipelined_data_memory.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_data_memory.sv
// Byte-addressable data memory for the MEM stage.
// Requests use a valid/ready handshake. Stores commit on the acceptance edge
// with byte strobes. Loads read on the acceptance edge and are extended one
// cycle later. Every accepted request gets one response exactly READ_LATENCY
// cycles after it is accepted. After reset, an optional clear sequence zeroes
// the array before any request is accepted.
module pipelined_data_memory #(
    parameter int DEPTH_WORDS    = 1024,
    parameter int ADDR_WIDTH     = 32,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  requestValid,
    output logic                  requestReady,
    input  logic                  requestWrite,
    input  logic [2:0]            func3,
    input  logic [ADDR_WIDTH-1:0] memoryAddress,
    input  logic [31:0]           writeData,
    output logic                  responseValid,
    output logic [31:0]           readData,
    output logic                  misalignedFault,
    output logic                  initBusy
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_READY;

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_clear_idx;
    logic [IDX_W-1:0] w_clear_idx_next;

    // Request decode
    logic             w_accept;
    logic [IDX_W-1:0] w_word_idx;
    logic [1:0]       w_off;
    logic             w_legal;
    logic             w_aligned;
    logic             w_fault;
    logic [3:0]       w_base_strb;
    logic [31:0]      w_lane_data;

    // Memory port
    logic [3:0]       w_mem_we;
    logic [IDX_W-1:0] w_mem_addr;
    logic [31:0]      w_mem_wdata;
    logic             w_rd_en;
    logic [31:0]      w_rd_word;

    // Attributes of the request accepted on the previous edge
    logic             r_acc_valid;
    logic             r_acc_load;
    logic             r_acc_fault;
    logic [2:0]       r_acc_func3;
    logic [1:0]       r_acc_off;

    logic [15:0]      w_shifted;
    logic [31:0]      w_ext;
    logic [33:0]      w_stage [READ_LATENCY];

    // The state register and clear index are reset asynchronously.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state     <= RESET_STATE;
            r_clear_idx <= '0;
        end else begin
            r_state     <= w_state_next;
            r_clear_idx <= w_clear_idx_next;
        end
    end

    // Next state: INIT walks the clear index once through the array, then stays in READY.
    always_comb begin
        w_state_next     = r_state;
        w_clear_idx_next = r_clear_idx;
        case (r_state)
            ST_INIT: begin
                w_clear_idx_next = r_clear_idx + ONE_IDX;
                if (r_clear_idx == LAST_IDX) begin
                    w_state_next = ST_READY;
                end
            end
            default: begin
                w_state_next = ST_READY;
            end
        endcase
    end

    // Status outputs are forced low while reset is held.
    assign initBusy     = resetN && (r_state == ST_INIT);
    assign requestReady = resetN && (r_state == ST_READY);

    assign w_accept   = requestValid && requestReady;
    assign w_word_idx = memoryAddress[IDX_W+1:2];
    assign w_off      = memoryAddress[1:0];

    // Upper address bits are ignored, so the address space wraps.
    generate
        if (ADDR_WIDTH > IDX_W + 2) begin : g_addr_hi
            logic w_unused_addr_bits;
            assign w_unused_addr_bits = ^memoryAddress[ADDR_WIDTH-1:IDX_W+2];
        end
    endgenerate

    // Decode the width code into legality, alignment, base strobe and lane data.
    // Narrow store data is replicated across lanes, so the strobe alone selects the placement.
    always_comb begin
        w_legal     = 1'b0;
        w_aligned   = 1'b0;
        w_base_strb = 4'b0000;
        w_lane_data = writeData;
        case (func3)
            3'b000: begin
                w_legal     = 1'b1;
                w_aligned   = 1'b1;
                w_base_strb = 4'b0001;
                w_lane_data = {4{writeData[7:0]}};
            end
            3'b001: begin
                w_legal     = 1'b1;
                w_aligned   = !w_off[0];
                w_base_strb = 4'b0011;
                w_lane_data = {2{writeData[15:0]}};
            end
            3'b010: begin
                w_legal     = 1'b1;
                w_aligned   = (w_off == 2'b00);
                w_base_strb = 4'b1111;
            end
            3'b100: begin
                w_legal   = !requestWrite;
                w_aligned = 1'b1;
            end
            3'b101: begin
                w_legal   = !requestWrite;
                w_aligned = !w_off[0];
            end
            default: begin
                w_legal   = 1'b0;
                w_aligned = 1'b0;
            end
        endcase
    end

    assign w_fault = !(w_legal && w_aligned);

    // Choose between clear writes and store writes. Both are blocked while
    // reset is low, so nothing can land once reset has been asserted.
    always_comb begin
        w_mem_we    = 4'b0000;
        w_mem_addr  = w_word_idx;
        w_mem_wdata = w_lane_data;
        if (resetN) begin
            if (r_state == ST_INIT) begin
                w_mem_we    = 4'b1111;
                w_mem_addr  = r_clear_idx;
                w_mem_wdata = '0;
            end else if (w_accept && requestWrite && !w_fault) begin
                w_mem_we = w_base_strb << w_off;
            end
        end
    end

    assign w_rd_en = w_accept && !requestWrite;

    // Each byte lane is a separate RAM with its own write enable and a registered read.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH_WORDS];
            logic [7:0] r_rd_byte;

            // Lane write and registered read. The array itself is not reset.
            always_ff @(posedge clock) begin
                if (w_mem_we[gi]) begin
                    r_mem[w_mem_addr] <= w_mem_wdata[gi*8 +: 8];
                end
                if (w_rd_en) begin
                    r_rd_byte <= r_mem[w_word_idx];
                end
            end

            assign w_rd_word[gi*8 +: 8] = r_rd_byte;
        end
    endgenerate

    // Capture the attributes of the accepted request, in step with the RAM read.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_acc_valid <= 1'b0;
            r_acc_load  <= 1'b0;
            r_acc_fault <= 1'b0;
            r_acc_func3 <= 3'b000;
            r_acc_off   <= 2'b00;
        end else begin
            r_acc_valid <= w_accept;
            r_acc_load  <= !requestWrite;
            r_acc_fault <= w_fault;
            r_acc_func3 <= func3;
            r_acc_off   <= w_off;
        end
    end

    assign w_shifted = 16'(w_rd_word >> {r_acc_off, 3'b000});

    // Extend the selected lane according to the load width code.
    always_comb begin
        w_ext = '0;
        case (r_acc_func3)
            3'b000:  w_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b100:  w_ext = {24'h000000, w_shifted[7:0]};
            3'b001:  w_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b101:  w_ext = {16'h0000, w_shifted[15:0]};
            3'b010:  w_ext = w_rd_word;
            default: w_ext = '0;
        endcase
    end

    // Stage 0 is the first response cycle. Stores and faults carry zero data.
    assign w_stage[0] = {r_acc_valid,
                         r_acc_valid && r_acc_fault,
                         (r_acc_valid && r_acc_load && !r_acc_fault) ? w_ext : 32'h0};

    // Each further stage adds one cycle of delay. Reset flushes the in-flight responses.
    generate
        for (gi = 1; gi < READ_LATENCY; gi++) begin : g_stage
            logic [33:0] r_stage;

            // Shift the response one stage further.
            always_ff @(posedge clock or negedge resetN) begin
                if (!resetN) begin
                    r_stage <= '0;
                end else begin
                    r_stage <= w_stage[gi-1];
                end
            end

            assign w_stage[gi] = r_stage;
        end
    endgenerate

    assign responseValid   = w_stage[READ_LATENCY-1][33];
    assign misalignedFault = w_stage[READ_LATENCY-1][32];
    assign readData        = w_stage[READ_LATENCY-1][31:0];

endmodule

// File: tb/tb_pipelined_data_memory.sv
// Self-checking bench for pipelined_data_memory.
// Two copies of the design (READ_LATENCY 1 and 3, DEPTH_WORDS 16) share the
// same stimulus. A byte-level reference model records the expected response
// for each accepted request. A compare process checks both copies on every cycle.
module tb_pipelined_data_memory;

    localparam int DW = 16;
    localparam int NB = DW * 4;
    localparam int NREC = 4096;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic        requestValid = 1'b0;
    logic        requestWrite = 1'b0;
    logic [2:0]  func3 = 3'b000;
    logic [31:0] memoryAddress = 32'h0;
    logic [31:0] writeData = 32'h0;

    logic        req_ready [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_data  [2];
    logic        rsp_fault [2];
    logic        init_busy [2];

    int checks = 0;
    int passes = 0;

    // Reference model state
    byte unsigned m_mem [NB];
    int           init_left = 0;
    int           edge_cnt = 0;
    bit           rec_v [NREC];
    bit           rec_f [NREC];
    logic [31:0]  rec_d [NREC];
    bit           m_flt;
    logic [31:0]  m_rdv;

    pipelined_data_memory #(
        .DEPTH_WORDS(DW), .ADDR_WIDTH(32), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
    ) u_dut_l1 (
        .clock(clock), .resetN(resetN), .requestValid(requestValid),
        .requestReady(req_ready[0]), .requestWrite(requestWrite), .func3(func3),
        .memoryAddress(memoryAddress), .writeData(writeData),
        .responseValid(rsp_valid[0]), .readData(rsp_data[0]),
        .misalignedFault(rsp_fault[0]), .initBusy(init_busy[0])
    );

    pipelined_data_memory #(
        .DEPTH_WORDS(DW), .ADDR_WIDTH(32), .READ_LATENCY(3), .CLEAR_ON_RESET(1)
    ) u_dut_l3 (
        .clock(clock), .resetN(resetN), .requestValid(requestValid),
        .requestReady(req_ready[1]), .requestWrite(requestWrite), .func3(func3),
        .memoryAddress(memoryAddress), .writeData(writeData),
        .responseValid(rsp_valid[1]), .readData(rsp_data[1]),
        .misalignedFault(rsp_fault[1]), .initBusy(init_busy[1])
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    endtask

    // The model works on a byte array: a width in bytes, a natural-alignment rule, little-endian assembly.
    function automatic void model_eval(input bit wr, input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] wd, output bit flt, output logic [31:0] rdv);
        int  size;
        int  base;
        bit  legal;
        bit  sgn;
        size = 1; legal = 1'b0; sgn = 1'b0;
        case (f)
            3'd0: begin size = 1; legal = 1'b1; sgn = 1'b1; end
            3'd1: begin size = 2; legal = 1'b1; sgn = 1'b1; end
            3'd2: begin size = 4; legal = 1'b1; end
            3'd4: begin size = 1; legal = !wr; end
            3'd5: begin size = 2; legal = !wr; end
            default: legal = 1'b0;
        endcase
        base = int'(a % NB);
        flt = !legal || ((base % size) != 0);
        rdv = 32'h0;
        if (!flt) begin
            if (wr) begin
                for (int i = 0; i < size; i++) m_mem[base + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < size; i++) rdv = rdv | (32'(m_mem[base + i]) << (8 * i));
                if (sgn && size < 4 && rdv[8*size-1]) rdv = rdv | (32'hFFFF_FFFF << (8 * size));
            end
        end
    endfunction

    task automatic model_reset();
        init_left = DW;
        for (int i = 0; i < NREC; i++) rec_v[i] = 1'b0;
        for (int i = 0; i < NB; i++) m_mem[i] = 8'h00;
    endtask

    // Model: count clock edges, step through the clear phase, and record each accepted request.
    always @(posedge clock) begin
        edge_cnt = edge_cnt + 1;
        if (resetN) begin
            if (init_left == 0) begin
                if (requestValid) begin
                    model_eval(requestWrite, func3, memoryAddress, writeData, m_flt, m_rdv);
                    rec_v[edge_cnt] = 1'b1;
                    rec_f[edge_cnt] = m_flt;
                    rec_d[edge_cnt] = (requestWrite || m_flt) ? 32'h0 : m_rdv;
                end
            end else begin
                init_left = init_left - 1;
            end
        end
    end

    // Compare both DUTs with the model just after every falling edge.
    initial begin
        forever begin
            @(negedge clock);
            #1;
            for (int k = 0; k < 2; k++) begin
                int  lat;
                int  idx;
                bit  ev;
                lat = (k == 0) ? 1 : 3;
                idx = edge_cnt - lat + 1;
                ev  = (idx >= 0) && (idx < NREC) && rec_v[idx];
                chk($sformatf("rsp_valid[L%0d]", lat), 32'(rsp_valid[k]), 32'(ev));
                if (ev) begin
                    chk($sformatf("rsp_data[L%0d]", lat), rsp_data[k], rec_d[idx]);
                    chk($sformatf("rsp_fault[L%0d]", lat), 32'(rsp_fault[k]), 32'(rec_f[idx]));
                end
                chk($sformatf("init_busy[L%0d]", lat), 32'(init_busy[k]), 32'(resetN && init_left > 0));
                chk($sformatf("req_ready[L%0d]", lat), 32'(req_ready[k]), 32'(resetN && init_left == 0));
            end
        end
    end

    task automatic issue(input bit wr, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clock);
        requestValid  = 1'b1;
        requestWrite  = wr;
        func3         = f;
        memoryAddress = a;
        writeData     = wd;
        $display("req %s f3=%0d addr=%h wdata=%h", wr ? "ST" : "LD", f, a, wd);
    endtask

    // Issue a request, then check the model's recorded response against a hand-computed value.
    task automatic issue_expect(input bit wr, input logic [2:0] f, input logic [31:0] a,
                                input logic [31:0] wd, input bit ef, input logic [31:0] ed);
        issue(wr, f, a, wd);
        @(posedge clock);
        #1;
        chk($sformatf("model_accept@%h", a), 32'(rec_v[edge_cnt]), 32'd1);
        chk($sformatf("model_data@%h", a), rec_d[edge_cnt], ed);
        chk($sformatf("model_fault@%h", a), 32'(rec_f[edge_cnt]), 32'(ef));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            requestValid = 1'b0;
        end
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        model_reset();
        $display("reset asserted t=%0t", $time);
    endtask

    // Release reset and count the cycles with initBusy high. The loop is bounded.
    task automatic release_and_count();
        int n0;
        int n1;
        n0 = 0; n1 = 0;
        @(negedge clock);
        requestValid = 1'b0;
        resetN = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (init_busy[0]) n0++;
            if (init_busy[1]) n1++;
            if (!init_busy[0] && !init_busy[1]) break;
            @(negedge clock);
        end
        chk("init_cycles[L1]", 32'(n0), 32'd16);
        chk("init_cycles[L3]", 32'(n1), 32'd16);
        $display("reset released, init cycles L1=%0d L3=%0d", n0, n1);
    endtask

    task automatic chk_all_zero();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_rsp_valid[%0d]", k), 32'(rsp_valid[k]), 32'd0);
            chk($sformatf("rst_rsp_data[%0d]", k), rsp_data[k], 32'd0);
            chk($sformatf("rst_rsp_fault[%0d]", k), 32'(rsp_fault[k]), 32'd0);
            chk($sformatf("rst_init_busy[%0d]", k), 32'(init_busy[k]), 32'd0);
            chk($sformatf("rst_req_ready[%0d]", k), 32'(req_ready[k]), 32'd0);
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clock);
        #1;
        chk_all_zero();
        release_and_count();

        // Fill the array with non-zero data, reset again, and expect INIT to zero every word.
        for (int i = 0; i < DW; i++) issue(1'b1, 3'd2, 32'(4 * i), 32'hA500_0000 | 32'(i + 1));
        idle(4);
        @(negedge clock);
        #2;
        do_reset();
        repeat (2) @(negedge clock);
        release_and_count();
        for (int i = 0; i < DW; i++) issue_expect(1'b0, 3'd2, 32'(4 * i), 32'h0, 1'b0, 32'h0);
        idle(4);

        // Merge SB and SH into an existing word.
        issue(1'b1, 3'd2, 32'h40, 32'h1122_3344);
        issue(1'b1, 3'd0, 32'h41, 32'h0000_00AB);
        issue(1'b1, 3'd1, 32'h42, 32'h0000_BEEF);
        issue_expect(1'b0, 3'd2, 32'h40, 32'h0, 1'b0, 32'hBEEF_AB44);
        idle(4);

        // Sign and zero extension of loads
        issue(1'b1, 3'd2, 32'h40, 32'h80FF_7F01);
        issue_expect(1'b0, 3'd0, 32'h43, 32'h0, 1'b0, 32'hFFFF_FF80);
        issue_expect(1'b0, 3'd4, 32'h43, 32'h0, 1'b0, 32'h0000_0080);
        issue_expect(1'b0, 3'd1, 32'h42, 32'h0, 1'b0, 32'hFFFF_80FF);
        issue_expect(1'b0, 3'd5, 32'h40, 32'h0, 1'b0, 32'h0000_7F01);
        issue_expect(1'b0, 3'd0, 32'h41, 32'h0, 1'b0, 32'h0000_007F);
        idle(4);

        // Misaligned requests and illegal width codes fault and leave memory unchanged.
        issue_expect(1'b1, 3'd1, 32'h41, 32'h0000_5555, 1'b1, 32'h0);
        issue_expect(1'b1, 3'd2, 32'h42, 32'h5555_5555, 1'b1, 32'h0);
        issue_expect(1'b0, 3'd2, 32'h43, 32'h0, 1'b1, 32'h0);
        issue_expect(1'b0, 3'd3, 32'h40, 32'h0, 1'b1, 32'h0);
        issue_expect(1'b1, 3'd4, 32'h40, 32'h0000_0066, 1'b1, 32'h0);
        issue_expect(1'b0, 3'd5, 32'h43, 32'h0, 1'b1, 32'h0);
        issue_expect(1'b0, 3'd2, 32'h40, 32'h0, 1'b0, 32'h80FF_7F01);
        idle(4);

        // Back-to-back loads, then a store and a load to the same word.
        // The addresses alias through the wrap.
        for (int i = 1; i <= 8; i++) issue(1'b1, 3'd2, 32'(4 * i), 32'h0102_0304 * i);
        idle(2);
        for (int i = 1; i <= 8; i++) issue_expect(1'b0, 3'd2, 32'(4 * i), 32'h0, 1'b0, 32'h0102_0304 * i);
        issue(1'b1, 3'd2, 32'h40 + NB, 32'hCAFE_F00D);
        issue_expect(1'b0, 3'd2, 32'h40, 32'h0, 1'b0, 32'hCAFE_F00D);
        idle(6);

        // Reset asserted mid-burst: in-flight responses are dropped and the pending store must not land.
        issue(1'b0, 3'd2, 32'h40, 32'h0);
        issue(1'b0, 3'd2, 32'h44, 32'h0);
        issue(1'b0, 3'd2, 32'h48, 32'h0);
        issue(1'b1, 3'd2, 32'h44, 32'h1234_5678);
        #2;
        do_reset();
        #1;
        chk_all_zero();
        repeat (3) @(negedge clock);
        release_and_count();
        issue_expect(1'b0, 3'd2, 32'h44, 32'h0, 1'b0, 32'h0);
        issue_expect(1'b0, 3'd2, 32'h40, 32'h0, 1'b0, 32'h0);
        idle(6);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
